spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: arbitrates instruction-fetch and data requests onto a single
// SPI memory controller, one transaction in flight at a time.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on a tie;
// when undefined the data port always wins a tie.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_start,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done
);

  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   pend_if;
  logic   pend_dm;
  logic   owner_dm;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_dm;
`endif

  logic cand_if_c;
  logic cand_dm_c;
  logic grant_dm_c;
  logic in_flight_c;
  logic accept_if_c;
  logic accept_dm_c;

  // Grant selection in IDLE and acceptance of new requests while busy
  always_comb begin
    cand_if_c   = if_req | pend_if;
    cand_dm_c   = dm_req | pend_dm;
    grant_dm_c  = cand_dm_c;
    if (cand_if_c && cand_dm_c) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_dm_c = ~last_dm;
`else
      grant_dm_c = 1'b1;
`endif
    end
    // The owner may not re-request until its ready cycle (RESP)
    in_flight_c = (state == ISSUE) || (state == WAIT);
    accept_if_c = ~(in_flight_c && !owner_dm);
    accept_dm_c = ~(in_flight_c && owner_dm);
  end

  // Transaction FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_if   <= 1'b0;
      pend_dm   <= 1'b0;
      owner_dm  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm   <= 1'b0;
`endif
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
    end else begin
      mem_start <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;

      case (state)
        IDLE: begin
          if (cand_if_c || cand_dm_c) begin
            state     <= ISSUE;
            mem_start <= 1'b1;
            owner_dm  <= grant_dm_c;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm   <= grant_dm_c;
`endif
            if (grant_dm_c) begin
              mem_we    <= dm_we;
              mem_size  <= dm_size;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              pend_dm   <= 1'b0;
              pend_if   <= cand_if_c;
            end else begin
              mem_we    <= 1'b0;
              mem_size  <= SIZE_WORD;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
              pend_if   <= 1'b0;
              pend_dm   <= cand_dm_c;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_done) begin
            state <= RESP;
            if (owner_dm) begin
              dm_ready <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if (!mem_we) if_rdata <= mem_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Requests arriving while a transaction is underway wait for next IDLE
      if (state != IDLE) begin
        if (if_req && accept_if_c) pend_if <= 1'b1;
        if (dm_req && accept_dm_c) pend_dm <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed stimulus with scoreboard queues for memory
// transactions and requester responses, plus a bench-side SPI memory model.
module tb_spi_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [23:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [23:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_start;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        resp_done;
  logic        stray_done;

  assign mem_done = resp_done | stray_done;

  spi_mem_arbiter #(.ADDR_W(24)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_start(mem_start), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  typedef struct {
    int          exp_cyc;
    bit          after_prev;
    bit          no_rsp;
    bit          we;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
  } rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_rsp[$];

  int cyc = 0;
  int done_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  bit resp_busy = 1'b0;

  logic [31:0] m_if = 32'd0;
  logic [31:0] m_dm = 32'd0;
  bit          m_last_dm = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one expected memory transaction and, unless dropped, its response
  task automatic push_txn(input bit is_dm, input int exp_cyc, input bit after_prev,
                          input bit no_rsp, input bit we, input logic [1:0] size,
                          input logic [23:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rdata);
    mem_t m;
    rsp_t r;
    m.exp_cyc = exp_cyc; m.after_prev = after_prev; m.no_rsp = no_rsp;
    m.we = we; m.size = size; m.addr = addr; m.wdata = wdata;
    m.delay = delay; m.rdata = rdata;
    exp_mem.push_back(m);
    m_last_dm = is_dm;
    if (!no_rsp) begin
      if (!we) begin
        if (is_dm) m_dm = rdata;
        else       m_if = rdata;
      end
      r.is_dm = is_dm; r.if_rd = m_if; r.dm_rd = m_dm;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_mem.size() != 0 || exp_rsp.size() != 0 || resp_busy) && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: mem left %0d rsp left %0d", exp_mem.size(), exp_rsp.size());
      exp_mem.delete();
      exp_rsp.delete();
    end
    repeat (4) step();
  endtask

  // Both requesters read in the same cycle; winner follows the tie-break rule
  task automatic tie_round(input logic [23:0] ai, input logic [23:0] ad,
                           input logic [31:0] ri, input logic [31:0] rd);
    int n;
    bit first_dm;
    n = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    first_dm = !m_last_dm;
`else
    first_dm = 1'b1;
`endif
    if (first_dm) begin
      push_txn(1'b1, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, ad, 32'd0, 3, rd);
      push_txn(1'b0, 0,     1'b1, 1'b0, 1'b0, 2'd2, ai, 32'd0, 2, ri);
    end else begin
      push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, ai, 32'd0, 2, ri);
      push_txn(1'b1, 0,     1'b1, 1'b0, 1'b0, 2'd2, ad, 32'd0, 3, rd);
    end
    if_addr = ai; dm_addr = ad; dm_we = 1'b0; dm_size = 2'd2; dm_wdata = 32'd0;
    if_req = 1'b1; dm_req = 1'b1;
    step();
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle();
  endtask

  // SPI memory model: checks each mem_start against the queue, then answers
  initial begin
    mem_t it;
    resp_done = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (mem_start) begin
        if (exp_mem.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_mem_start: cycle %0d addr %h", cyc, mem_addr);
          it.delay = 2; it.rdata = 32'd0; it.no_rsp = 1'b1; it.addr = '0;
        end else begin
          it = exp_mem.pop_front();
          if (it.after_prev) chk("start_cycle", 32'(cyc), 32'(done_cyc + 3));
          else               chk("start_cycle", 32'(cyc), 32'(it.exp_cyc));
          chk("mem_we",    32'(mem_we),   32'(it.we));
          chk("mem_size",  32'(mem_size), 32'(it.size));
          chk("mem_addr",  32'(mem_addr), 32'(it.addr));
          if (it.we) chk("mem_wdata", mem_wdata, it.wdata);
        end
        resp_busy = 1'b1;
        repeat (it.delay) @(posedge clk);
        #1;
        mem_rdata = it.rdata;
        resp_done = 1'b1;
        done_cyc  = cyc;
        if (!it.no_rsp) chk("mem_addr_stable", 32'(mem_addr), 32'(it.addr));
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        resp_busy = 1'b0;
      end
    end
  end

  // Response monitor: every ready pulse must match the head of the queue
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: if_ready %0b dm_ready %0b cycle %0d", if_ready, dm_ready, cyc);
        end else begin
          r = exp_rsp.pop_front();
          chk("dm_ready", 32'(dm_ready), 32'(r.is_dm));
          chk("if_ready", 32'(if_ready), 32'(!r.is_dm));
          chk("ready_latency", 32'(cyc), 32'(done_cyc + 1));
          chk("if_rdata", if_rdata, r.if_rd);
          chk("dm_rdata", dm_rdata, r.dm_rd);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int t;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0; dm_addr = '0; dm_wdata = 32'd0;
    stray_done = 1'b0;
    repeat (3) step();
    chk("rst_mem_start", 32'(mem_start), 32'd0);
    chk("rst_if_ready",  32'(if_ready),  32'd0);
    chk("rst_dm_ready",  32'(dm_ready),  32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_size",  32'(mem_size),  32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_dm_rdata",  dm_rdata,       32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Three same-cycle rounds from reset
    tie_round(24'h000010, 24'h800010, 32'hA0000001, 32'hB0000001);
    tie_round(24'h000020, 24'h800020, 32'hA0000002, 32'hB0000002);
    tie_round(24'h000030, 24'h800030, 32'hA0000003, 32'hB0000003);

    // Fetch read, done five cycles after mem_start
    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h000100, 32'd0, 5, 32'hDEADBEEF);
    if_addr = 24'h000100; if_req = 1'b1;
    step();
    if_req = 1'b0;
    wait_idle();

    // Data word read, gives dm_rdata a known nonzero value
    n = cyc;
    push_txn(1'b1, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h800040, 32'd0, 2, 32'hCAFEF00D);
    dm_addr = 24'h800040; dm_we = 1'b0; dm_size = 2'd2; dm_req = 1'b1;
    step();
    dm_req = 1'b0;
    wait_idle();

    // Data byte write; dm_rdata must keep its previous value
    n = cyc;
    push_txn(1'b1, n + 1, 1'b0, 1'b0, 1'b1, 2'd0, 24'h800004, 32'h000000A5, 3, 32'h12345678);
    dm_addr = 24'h800004; dm_we = 1'b1; dm_size = 2'd0; dm_wdata = 32'h000000A5; dm_req = 1'b1;
    step();
    dm_req = 1'b0;
    wait_idle();

    // Tie right after a data grant: the two builds differ here
    tie_round(24'h000050, 24'h800050, 32'hA0000005, 32'hB0000005);

    // Fetch re-requests during its own ready cycle
    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h000200, 32'd0, 2, 32'h11111111);
    push_txn(1'b0, 0,     1'b1, 1'b0, 1'b0, 2'd2, 24'h000204, 32'd0, 2, 32'h22222222);
    if_addr = 24'h000200; if_req = 1'b1;
    step();
    if_req = 1'b0;
    t = 0;
    while (!if_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if_addr = 24'h000204; if_req = 1'b1;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    wait_idle();

    // Data request while fetch is in WAIT is held until fetch completes
    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h000300, 32'd0, 4, 32'h33333333);
    push_txn(1'b1, 0,     1'b1, 1'b0, 1'b0, 2'd2, 24'h800020, 32'd0, 2, 32'h44444444);
    if_addr = 24'h000300; if_req = 1'b1;
    step();
    if_req = 1'b0;
    step();
    dm_addr = 24'h800020; dm_we = 1'b0; dm_size = 2'd2; dm_req = 1'b1;
    step();
    dm_req = 1'b0;
    wait_idle();

    // Reset during WAIT with a data request pending; late mem_done follows
    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b1, 1'b0, 2'd2, 24'h000400, 32'd0, 6, 32'h99999999);
    if_addr = 24'h000400; if_req = 1'b1;
    step();
    if_req = 1'b0;
    step();
    dm_addr = 24'h800060; dm_we = 1'b0; dm_size = 2'd2; dm_req = 1'b1;
    step();
    dm_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_mem_start", 32'(mem_start), 32'd0);
    chk("mid_rst_if_ready",  32'(if_ready),  32'd0);
    chk("mid_rst_dm_ready",  32'(dm_ready),  32'd0);
    chk("mid_rst_if_rdata",  if_rdata,       32'd0);
    chk("mid_rst_dm_rdata",  dm_rdata,       32'd0);
    chk("mid_rst_mem_addr",  32'(mem_addr),  32'd0);
    rst = 1'b0;
    m_if = 32'd0; m_dm = 32'd0; m_last_dm = 1'b0;
    wait_idle();

    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h000500, 32'd0, 2, 32'h55555555);
    if_addr = 24'h000500; if_req = 1'b1;
    step();
    if_req = 1'b0;
    wait_idle();

    // Stray mem_done in IDLE, then repeated fetch requests while in flight
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (3) step();
    n = cyc;
    push_txn(1'b0, n + 1, 1'b0, 1'b0, 1'b0, 2'd2, 24'h000600, 32'd0, 3, 32'h66666666);
    if_addr = 24'h000600; if_req = 1'b1;
    step();
    step();
    if_req = 1'b0;
    step();
    if_req = 1'b1;
    step();
    if_req = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
